// File: rtl/rv32i_core.sv
// rv32i_core: two-stage RV32I integer core. Stage 1 fetches, decodes, executes and
// accesses data memory in a single cycle; the WB register feeds the register file.
module rv32i_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_im,
    input  logic        write_en,
    input  logic [9:0]  write_addr,
    input  logic [31:0] write_data,
    output logic [31:0] pc,
    output logic [31:0] s_alu_result_out,
    output logic [31:0] s_load_data_out,
    output logic [4:0]  s_rd_out,
    output logic        s_wb_reg_file_out,
    output logic        s_memtoreg_out
);

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    logic [31:0] imem [1024];
    logic [31:0] dmem [256];
    logic [31:0] regs [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] wb_value;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] next_pc;
    logic [31:0] result;
    logic [31:0] load_word;
    logic        reg_write;
    logic        mem_to_reg;
    logic        store;
    logic        take;
    logic        imm_legal;
    logic        op_legal;

    assign instr  = imem[pc[11:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign wb_value = s_memtoreg_out ? s_load_data_out : s_alu_result_out;

    // The WB entry reaches the register file one edge late, so forward it here.
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                     (s_wb_reg_file_out && s_rd_out == rs1) ? wb_value : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                     (s_wb_reg_file_out && s_rd_out == rs2) ? wb_value : regs[rs2];

    function automatic logic [31:0] alu(input logic [2:0]  f3,
                                        input logic        alt,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        case (funct3)
            3'b001:  imm_legal = (funct7 == 7'd0);
            3'b101:  imm_legal = (funct7 == 7'd0) || (funct7 == 7'b0100000);
            default: imm_legal = 1'b1;
        endcase
    end

    assign op_legal = (funct7 == 7'd0) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));

    always_comb begin
        next_pc    = pc + 32'd4;
        result     = 32'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        store      = 1'b0;
        take       = 1'b0;
        case (opcode)
            OPC_LUI: begin
                result    = imm_u;
                reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                result    = pc + imm_u;
                reg_write = 1'b1;
            end
            OPC_JAL: begin
                result    = pc + 32'd4;
                next_pc   = pc + imm_j;
                reg_write = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    result    = pc + 32'd4;
                    next_pc   = (rs1_val + imm_i) & ~32'd1;
                    reg_write = 1'b1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  take = (rs1_val == rs2_val);
                    3'b001:  take = (rs1_val != rs2_val);
                    3'b100:  take = ($signed(rs1_val) <  $signed(rs2_val));
                    3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  take = (rs1_val <  rs2_val);
                    3'b111:  take = (rs1_val >= rs2_val);
                    default: take = 1'b0;
                endcase
                if (take) next_pc = pc + imm_b;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    result     = rs1_val + imm_i;
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    result = rs1_val + imm_s;
                    store  = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (imm_legal) begin
                    result    = alu(funct3, funct3 == 3'b101 && funct7[5], rs1_val, imm_i);
                    reg_write = 1'b1;
                end
            end
            OPC_OP: begin
                if (op_legal) begin
                    result    = alu(funct3, funct7[5], rs1_val, rs2_val);
                    reg_write = 1'b1;
                end
            end
            default: ;
        endcase
        if (rd == 5'd0) reg_write = 1'b0;
    end

    assign load_word = dmem[result[9:2]];

    // Clearing takes precedence over a concurrent write; rst never touches this array.
    always_ff @(posedge clk) begin
        if (rst_im) begin
            for (int i = 0; i < 1024; i++) imem[i] <= NOP_WORD;
        end else if (write_en) begin
            imem[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && store) dmem[result[9:2]] <= rs2_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (s_wb_reg_file_out && s_rd_out != 5'd0) begin
            regs[s_rd_out] <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc                <= 32'd0;
            s_alu_result_out  <= 32'd0;
            s_load_data_out   <= 32'd0;
            s_rd_out          <= 5'd0;
            s_wb_reg_file_out <= 1'b0;
            s_memtoreg_out    <= 1'b0;
        end else begin
            pc                <= next_pc;
            s_alu_result_out  <= result;
            s_load_data_out   <= load_word;
            s_rd_out          <= reg_write ? rd : 5'd0;
            s_wb_reg_file_out <= reg_write;
            s_memtoreg_out    <= mem_to_reg;
        end
    end

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: instruction-level reference model drives a scoreboard; a monitor
// compares every WB-stage output against the model's architectural results.
module tb_rv32i_core;

    logic        clk;
    logic        rst;
    logic        rst_im;
    logic        write_en;
    logic [9:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pc;
    logic [31:0] s_alu_result_out;
    logic [31:0] s_load_data_out;
    logic [4:0]  s_rd_out;
    logic        s_wb_reg_file_out;
    logic        s_memtoreg_out;

    rv32i_core dut (
        .clk               (clk),
        .rst               (rst),
        .rst_im            (rst_im),
        .write_en          (write_en),
        .write_addr        (write_addr),
        .write_data        (write_data),
        .pc                (pc),
        .s_alu_result_out  (s_alu_result_out),
        .s_load_data_out   (s_load_data_out),
        .s_rd_out          (s_rd_out),
        .s_wb_reg_file_out (s_wb_reg_file_out),
        .s_memtoreg_out    (s_memtoreg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        wb;
        logic        mtr;
        logic        chk_alu;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] prog_q[$];
    logic [31:0] m_imem [1024];
    logic [31:0] m_dmem [256];
    logic [31:0] m_x [32];
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [31:0] r;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          off;
        r   = $urandom;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = r[14:12];
        case ($urandom_range(0, 12))
            0: w = {r[31:12], rd, 7'h37};
            1: w = {r[31:12], rd, 7'h17};
            2: begin
                off = int'($urandom_range(1, 6)) * 4;
                if (r[31]) off = -off;
                w = enc_j(off[20:0], rd);
            end
            3: w = enc_i({4'd0, r[5:0], 2'b00}, rs1, 3'b000, rd, 7'h67);
            4: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b100;
                    3: f3 = 3'b101;
                    4: f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
                off = int'($urandom_range(1, 4)) * 4;
                if (r[31]) off = -off;
                w = enc_b(off[12:0], rs2, rs1, f3);
            end
            5: w = enc_i(r[11:0], rs1, 3'b010, rd, 7'h03);
            6: w = enc_s(r[11:0], rs2, rs1);
            7, 8: begin
                if (f3 == 3'b001)      w = enc_i({7'd0, r[4:0]}, rs1, f3, rd, 7'h13);
                else if (f3 == 3'b101) w = enc_i({1'b0, r[20], 5'd0, r[4:0]}, rs1, f3, rd, 7'h13);
                else                   w = enc_i(r[11:0], rs1, f3, rd, 7'h13);
            end
            9, 10: begin
                f7 = ((f3 == 3'b000 || f3 == 3'b101) && r[20]) ? 7'h20 : 7'h00;
                w  = enc_r(f7, rs2, rs1, f3, rd);
            end
            11: begin
                case (r[1:0])
                    2'd0:    w = 32'd0;
                    2'd1:    w = {r[31:7], 7'h7F};
                    2'd2:    w = enc_i(r[11:0], rs1, 3'b000, rd, 7'h03);
                    default: w = enc_r(7'h01, rs2, rs1, f3, rd);
                endcase
            end
            default: w = enc_i(r[11:0], rs1, 3'b000, rd, 7'h13);
        endcase
        return w;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  r = (a < b) ? 32'd1 : 32'd0;
            3'b100:  r = a ^ b;
            3'b101: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        for (int k = 0; k < 32; k++) m_x[k] = 32'd0;
    endtask

    // Executes the instruction at m_pc architecturally and returns what WB must show.
    task automatic model_step(output exp_t e);
        logic [31:0] i, a, b, nxt, res;
        logic [31:0] im_i, im_s, im_b, im_u, im_j;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        wb, mtr, st, legal, tk;
        i    = m_imem[m_pc[11:2]];
        rd   = i[11:7];
        f3   = i[14:12];
        f7   = i[31:25];
        a    = m_x[i[19:15]];
        b    = m_x[i[24:20]];
        im_i = {{20{i[31]}}, i[31:20]};
        im_s = {{20{i[31]}}, i[31:25], i[11:7]};
        im_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        im_u = {i[31:12], 12'd0};
        im_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        nxt = m_pc + 32'd4;
        res = 32'd0;
        wb = 1'b0; mtr = 1'b0; st = 1'b0; legal = 1'b1; tk = 1'b0;
        case (i[6:0])
            7'h37: begin res = im_u; wb = 1'b1; end
            7'h17: begin res = m_pc + im_u; wb = 1'b1; end
            7'h6F: begin res = m_pc + 32'd4; nxt = m_pc + im_j; wb = 1'b1; end
            7'h67: begin
                if (f3 == 3'b000) begin
                    res = m_pc + 32'd4;
                    nxt = (a + im_i) & 32'hFFFF_FFFE;
                    wb  = 1'b1;
                end else legal = 1'b0;
            end
            7'h63: begin
                case (f3)
                    3'b000: tk = (a == b);
                    3'b001: tk = (a != b);
                    3'b100: tk = ($signed(a) < $signed(b));
                    3'b101: tk = !($signed(a) < $signed(b));
                    3'b110: tk = (a < b);
                    3'b111: tk = !(a < b);
                    default: legal = 1'b0;
                endcase
                if (tk) nxt = m_pc + im_b;
            end
            7'h03: begin
                if (f3 == 3'b010) begin res = a + im_i; wb = 1'b1; mtr = 1'b1; end
                else legal = 1'b0;
            end
            7'h23: begin
                if (f3 == 3'b010) begin res = a + im_s; st = 1'b1; end
                else legal = 1'b0;
            end
            7'h13: begin
                if ((f3 == 3'b001 && f7 != 7'h00) ||
                    (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) legal = 1'b0;
                else begin
                    res = ref_alu(f3, f3 == 3'b101 && f7 == 7'h20, a, im_i);
                    wb  = 1'b1;
                end
            end
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    res = ref_alu(f3, f7 == 7'h20, a, b);
                    wb  = 1'b1;
                end else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            res = 32'd0; wb = 1'b0; mtr = 1'b0; st = 1'b0; nxt = m_pc + 32'd4;
        end
        if (rd == 5'd0) wb = 1'b0;
        e.ld = m_dmem[res[9:2]];
        if (st) m_dmem[res[9:2]] = b;
        if (wb) m_x[rd] = mtr ? e.ld : res;
        e.alu     = res;
        e.rd      = rd;
        e.wb      = wb;
        e.mtr     = mtr;
        e.chk_alu = legal;
        m_pc      = nxt;
    endtask

    // Holds the core in reset, clears imem (with a competing write to word 0), loads prog_q.
    task automatic load_program();
        @(negedge clk);
        rst        = 1'b1;
        rst_im     = 1'b1;
        write_en   = 1'b1;
        write_addr = 10'd0;
        write_data = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
        for (int k = 0; k < 1024; k++) m_imem[k] = 32'h0000_0013;
        @(negedge clk);
        rst_im = 1'b0;
        for (int k = 0; k < prog_q.size(); k++) begin
            write_addr = 10'(k);
            write_data = prog_q[k];
            m_imem[k]  = prog_q[k];
            @(negedge clk);
        end
        write_en = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"},  pc, 32'd0);
        check({tag, "_alu"}, s_alu_result_out, 32'd0);
        check({tag, "_ld"},  s_load_data_out, 32'd0);
        check({tag, "_rd"},  32'(s_rd_out), 32'd0);
        check({tag, "_wb"},  32'(s_wb_reg_file_out), 32'd0);
        check({tag, "_mtr"}, 32'(s_memtoreg_out), 32'd0);
    endtask

    task automatic directed_check(input int c);
        case (c)
            1: begin
                check("d_addi1_rd",  32'(s_rd_out), 32'd1);
                check("d_addi1_alu", s_alu_result_out, 32'd5);
                check("d_addi1_wb",  32'(s_wb_reg_file_out), 32'd1);
                check("d_addi1_mtr", 32'(s_memtoreg_out), 32'd0);
            end
            2: begin
                check("d_bypass_rd",  32'(s_rd_out), 32'd2);
                check("d_bypass_alu", s_alu_result_out, 32'd8);
            end
            3: begin
                check("d_sw_wb",  32'(s_wb_reg_file_out), 32'd0);
                check("d_sw_alu", s_alu_result_out, 32'd0);
            end
            4: begin
                check("d_lw_alu", s_alu_result_out, 32'd0);
                check("d_lw_ld",  s_load_data_out, 32'd8);
                check("d_lw_rd",  32'(s_rd_out), 32'd3);
                check("d_lw_mtr", 32'(s_memtoreg_out), 32'd1);
                check("d_lw_wb",  32'(s_wb_reg_file_out), 32'd1);
            end
            5: begin
                check("d_beq_pc", pc, 32'h18);
                check("d_beq_wb", 32'(s_wb_reg_file_out), 32'd0);
            end
            6: begin
                check("d_add_rd",  32'(s_rd_out), 32'd5);
                check("d_add_alu", s_alu_result_out, 32'd13);
            end
            default: ;
        endcase
    endtask

    // Called at a negedge with rst high; releases reset and runs n instructions.
    task automatic run(input int n, input bit directed);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            if (c == 0) rst = 1'b0;
            check("pc", pc, m_pc);
            if (directed) directed_check(c);
            model_step(e);
            sb_q.push_back(e);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("wb_en",  32'(s_wb_reg_file_out), 32'(e.wb));
                check("wb_mtr", 32'(s_memtoreg_out), 32'(e.mtr));
                if (e.wb)      check("wb_rd",  32'(s_rd_out), 32'(e.rd));
                if (e.chk_alu) check("wb_alu", s_alu_result_out, e.alu);
                if (e.mtr)     check("wb_ld",  s_load_data_out, e.ld);
            end
        end
    end

    initial begin : stimulus
        rst        = 1'b1;
        rst_im     = 1'b0;
        write_en   = 1'b0;
        write_addr = 10'd0;
        write_data = 32'd0;
        for (int k = 0; k < 256; k++) m_dmem[k] = 32'd0;

        // Zero all of data memory so later loads have known contents.
        prog_q.delete();
        prog_q.push_back(enc_i(12'd0, 5'd0, 3'b000, 5'd1, 7'h13));
        prog_q.push_back(enc_i(12'h400, 5'd0, 3'b000, 5'd2, 7'h13));
        prog_q.push_back(enc_s(12'd0, 5'd0, 5'd1));
        prog_q.push_back(enc_i(12'd4, 5'd1, 3'b000, 5'd1, 7'h13));
        prog_q.push_back(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001));
        prog_q.push_back(enc_j(21'd0, 5'd0));
        load_program();
        check_reset("rst_clr");
        run(780, 1'b0);

        prog_q.delete();
        prog_q.push_back(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13));
        prog_q.push_back(enc_i(12'd3, 5'd1, 3'b000, 5'd2, 7'h13));
        prog_q.push_back(enc_s(12'd0, 5'd2, 5'd0));
        prog_q.push_back(enc_i(12'd0, 5'd0, 3'b010, 5'd3, 7'h03));
        prog_q.push_back(enc_b(13'd8, 5'd0, 5'd0, 3'b000));
        prog_q.push_back(enc_i(12'd1, 5'd0, 3'b000, 5'd4, 7'h13));
        prog_q.push_back(enc_r(7'h00, 5'd1, 5'd3, 3'b000, 5'd5));
        load_program();
        check_reset("rst_dir");
        run(10, 1'b1);

        prog_q.delete();
        load_program();
        check_reset("rst_nop");
        run(24, 1'b0);

        for (int p = 0; p < 8; p++) begin
            prog_q.delete();
            for (int k = 0; k < 64; k++) prog_q.push_back(rand_instr());
            load_program();
            check_reset("rst_rand");
            run(150, 1'b0);
            if (p % 2 == 1) begin
                check_reset("rst_mid");
                model_reset();
                run(60, 1'b0);
            end
        end

        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
